// File: rtl/ttl_checksum_update.sv
// ttl_checksum_update
//
// Egress rewrite stage placed after the output-port lookup. For IPv4
// packets that are forwarded to one of the four MAC ports, it decrements
// the TTL, updates the IPv4 header checksum incrementally, and replaces
// the Ethernet source MAC with the MAC of the egress port. Packets sent to
// a CPU port and non-IPv4 packets pass through unchanged.
//
// The stage holds one output register and one skid register. This keeps
// full throughput under backpressure. S_AXIS_TREADY comes straight from a
// flop.
//
// Ports:
//   AXI_ACLK, AXI_RESETN        clock, asynchronous active-low reset
//   S_AXIS_*                    input stream (TDATA/TSTRB/TUSER/TVALID/TLAST, TREADY out)
//   M_AXIS_*                    output stream (TDATA/TSTRB/TUSER/TVALID/TLAST, TREADY in)
//   reset                       counter clear, active when equal to 1
//   macN_low / macN_high        MAC[31:0] / MAC[47:32] (in [15:0]) of MAC port N
//   rewrite_count               number of packets rewritten
//   passthru_count              number of packets forwarded unmodified
module ttl_checksum_update #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,

  input  logic [C_S_AXI_DATA_WIDTH-1:0]       reset,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac0_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac0_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac1_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac1_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac2_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac2_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac3_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac3_high,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       rewrite_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       passthru_count
);

  localparam logic [0:0] HEADER = 1'b0;
  localparam logic [0:0] BODY   = 1'b1;

  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]                          state;
  logic                                in_accept;
  logic                                first_beat;

  logic [7:0]                          dst_ports;
  logic                                port_hit;
  logic [47:0]                         port_mac;
  logic [15:0]                         ethertype;
  logic [3:0]                          ip_version;
  logic [7:0]                          ip_ttl;
  logic [15:0]                         ip_cksum;
  logic [16:0]                         cksum_sum;
  logic [15:0]                         cksum_new;
  logic                                do_rewrite;
  logic [C_S_AXIS_DATA_WIDTH-1:0]      beat_data;

  logic                                s_ready_q;
  logic                                or_valid;
  logic [C_M_AXIS_DATA_WIDTH-1:0]      or_tdata;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    or_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]     or_tuser;
  logic                                or_tlast;
  logic                                sk_valid;
  logic [C_M_AXIS_DATA_WIDTH-1:0]      sk_tdata;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    sk_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]     sk_tuser;
  logic                                sk_tlast;

  logic                                unused_mac_high;

  // Only the low 16 bits of each macN_high register hold MAC bits.
  assign unused_mac_high = ^{mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                             mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};

  assign in_accept  = S_AXIS_TVALID & s_ready_q;
  assign first_beat = (state == HEADER);

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = or_valid;
  assign M_AXIS_TDATA  = or_tdata;
  assign M_AXIS_TSTRB  = or_tstrb;
  assign M_AXIS_TUSER  = or_tuser;
  assign M_AXIS_TLAST  = or_tlast;

  // Select the egress MAC. The match is exact on the whole one-hot byte,
  // so a packet that is also copied to a CPU port (extra bits set) is not
  // treated as a plain MAC-port forward.
  always_comb begin
    dst_ports = S_AXIS_TUSER[DST_PORT_POS +: 8];
    port_hit  = 1'b1;
    port_mac  = 48'd0;
    case (dst_ports)
      8'h01:   port_mac = {mac0_high[15:0], mac0_low};
      8'h04:   port_mac = {mac1_high[15:0], mac1_low};
      8'h10:   port_mac = {mac2_high[15:0], mac2_low};
      8'h40:   port_mac = {mac3_high[15:0], mac3_low};
      default: port_hit = 1'b0;
    endcase
  end

  // Build the rewritten first beat. Decrementing the TTL lowers the
  // 16-bit word {TTL, protocol} by 0x0100. In one's complement this means
  // the stored (inverted) checksum rises by 0x0100, and any carry is
  // folded back into bit 0.
  always_comb begin
    ethertype  = S_AXIS_TDATA[159:144];
    ip_version = S_AXIS_TDATA[143:140];
    ip_ttl     = S_AXIS_TDATA[79:72];
    ip_cksum   = S_AXIS_TDATA[63:48];
    cksum_sum  = {1'b0, ip_cksum} + 17'h00100;
    cksum_new  = cksum_sum[15:0] + {15'd0, cksum_sum[16]};
    do_rewrite = first_beat && port_hit && (ethertype == 16'h0800) &&
                 (ip_version == 4'd4) && (ip_ttl > 8'd1);
    beat_data  = S_AXIS_TDATA;
    if (do_rewrite) begin
      beat_data[207:160] = port_mac;
      beat_data[79:72]   = ip_ttl - 8'd1;
      beat_data[63:48]   = cksum_new;
    end
  end

  // Packet framing. Only the beat accepted in HEADER is a candidate for
  // rewrite. A single-beat packet never leaves HEADER.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state <= HEADER;
    end else if (in_accept) begin
      if (state == HEADER && !S_AXIS_TLAST) begin
        state <= BODY;
      end else if (state == BODY && S_AXIS_TLAST) begin
        state <= HEADER;
      end
    end
  end

  // Output register with a skid register behind it. When the output
  // register can move, it takes the skid contents first. Otherwise it takes
  // the incoming beat. A beat that arrives while the output is stalled goes
  // into the skid register. Input ready is set from the flop in the same
  // cycle the skid register fills, so no beat arrives while it is full.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      s_ready_q <= 1'b1;
      or_valid  <= 1'b0;
      or_tdata  <= '0;
      or_tstrb  <= '0;
      or_tuser  <= '0;
      or_tlast  <= 1'b0;
      sk_valid  <= 1'b0;
      sk_tdata  <= '0;
      sk_tstrb  <= '0;
      sk_tuser  <= '0;
      sk_tlast  <= 1'b0;
    end else if (!or_valid || M_AXIS_TREADY) begin
      if (sk_valid) begin
        or_valid  <= 1'b1;
        or_tdata  <= sk_tdata;
        or_tstrb  <= sk_tstrb;
        or_tuser  <= sk_tuser;
        or_tlast  <= sk_tlast;
        sk_valid  <= 1'b0;
        s_ready_q <= 1'b1;
      end else if (in_accept) begin
        or_valid  <= 1'b1;
        or_tdata  <= beat_data;
        or_tstrb  <= S_AXIS_TSTRB;
        or_tuser  <= S_AXIS_TUSER;
        or_tlast  <= S_AXIS_TLAST;
      end else begin
        or_valid  <= 1'b0;
      end
    end else if (in_accept) begin
      sk_valid  <= 1'b1;
      sk_tdata  <= beat_data;
      sk_tstrb  <= S_AXIS_TSTRB;
      sk_tuser  <= S_AXIS_TUSER;
      sk_tlast  <= S_AXIS_TLAST;
      s_ready_q <= 1'b0;
    end
  end

  // Per-packet statistics. Each packet is counted once, on its first beat.
  // A software clear wins over an increment in the same cycle.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      rewrite_count  <= '0;
      passthru_count <= '0;
    end else if (reset == CNT_ONE) begin
      rewrite_count  <= '0;
      passthru_count <= '0;
    end else if (in_accept && first_beat) begin
      if (do_rewrite) begin
        rewrite_count  <= rewrite_count + CNT_ONE;
      end else begin
        passthru_count <= passthru_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ttl_checksum_update.sv
// tb_ttl_checksum_update
//
// Directed testbench for ttl_checksum_update. The vectors cover:
//   - IPv4 rewrites to each MAC port, including checksum carry wrap.
//   - Pass-through cases.
//   - Skid-buffer backpressure.
//   - Back-to-back packets.
//   - Reset in the middle of a packet.
//   - Counter clear.
// Expected beats are built from hand-computed field values.
module tb_ttl_checksum_update;

  logic         AXI_ACLK;
  logic         AXI_RESETN;
  logic [255:0] S_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TREADY;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY;
  logic [31:0]  reset;
  logic [31:0]  mac0_low, mac0_high, mac1_low, mac1_high;
  logic [31:0]  mac2_low, mac2_high, mac3_low, mac3_high;
  logic [31:0]  rewrite_count;
  logic [31:0]  passthru_count;

  int checks = 0;
  int failures = 0;

  localparam logic [47:0] ORIG_SRC = 48'h0011_2233_4455;
  localparam logic [47:0] MAC0 = 48'h0102_0304_0506;
  localparam logic [47:0] MAC1 = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] MAC2 = 48'h1A1B_1C1D_1E1F;
  localparam logic [47:0] MAC3 = 48'h2A2B_2C2D_2E2F;

  ttl_checksum_update dut (
    .AXI_ACLK       (AXI_ACLK),
    .AXI_RESETN     (AXI_RESETN),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TSTRB   (S_AXIS_TSTRB),
    .S_AXIS_TUSER   (S_AXIS_TUSER),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TSTRB   (M_AXIS_TSTRB),
    .M_AXIS_TUSER   (M_AXIS_TUSER),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .reset          (reset),
    .mac0_low       (mac0_low),
    .mac0_high      (mac0_high),
    .mac1_low       (mac1_low),
    .mac1_high      (mac1_high),
    .mac2_low       (mac2_low),
    .mac2_high      (mac2_high),
    .mac3_low       (mac3_low),
    .mac3_high      (mac3_high),
    .rewrite_count  (rewrite_count),
    .passthru_count (passthru_count)
  );

  // 100 MHz clock
  initial begin
    AXI_ACLK = 1'b0;
    forever #5 AXI_ACLK = ~AXI_ACLK;
  end

  // Builds a first-beat image. Bits outside the named fields carry a fixed
  // filler pattern.
  function automatic logic [255:0] makeBeat(input logic [47:0] src, input logic [15:0] et,
                                            input logic [3:0] ver, input logic [7:0] ttl,
                                            input logic [15:0] ck);
    logic [255:0] b;
    b = {8{32'hC3A5_5A3C}};
    b[255:208] = 48'hFFEE_DDCC_BBAA;
    b[207:160] = src;
    b[159:144] = et;
    b[143:140] = ver;
    b[79:72]   = ttl;
    b[63:48]   = ck;
    return b;
  endfunction

  function automatic logic [127:0] makeUser(input logic [7:0] dst);
    logic [127:0] u;
    u = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    u[31:24] = dst;
    return u;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] d, input logic [127:0] u,
                               input logic [31:0] strb, input logic last);
    S_AXIS_TDATA  = d;
    S_AXIS_TUSER  = u;
    S_AXIS_TSTRB  = strb;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
  endtask

  task automatic stepCycle();
    @(posedge AXI_ACLK);
    #1;
  endtask

  // Sends one single-beat packet with the output always ready. The result
  // must show up one cycle later, and the output must go idle after that.
  task automatic sendSingle(input string tag, input logic [255:0] d, input logic [7:0] dst,
                            input logic [255:0] expd);
    applyStimulus(d, makeUser(dst), 32'hFFFF_FFFF, 1'b1);
    stepCycle();
    S_AXIS_TVALID = 1'b0;
    checkOutput({tag, "_valid"}, 256'(M_AXIS_TVALID), 256'(1'b1));
    checkOutput({tag, "_data"}, M_AXIS_TDATA, expd);
    checkOutput({tag, "_user"}, 256'(M_AXIS_TUSER), 256'(makeUser(dst)));
    checkOutput({tag, "_last"}, 256'(M_AXIS_TLAST), 256'(1'b1));
    stepCycle();
    checkOutput({tag, "_idle"}, 256'(M_AXIS_TVALID), 256'(1'b0));
  endtask

  logic [255:0] bpIn [3];
  logic [255:0] bpExp [3];
  logic [31:0]  bpStrb [3];
  logic         rdySeq [6];
  logic [255:0] bbIn [5];
  logic [255:0] bbExp [5];
  logic [7:0]   bbDst [5];
  logic         bbLast [5];

  initial begin
    int inIdx, outIdx, occ;
    logic heldValid, inAcc, outAcc;
    logic [255:0] held;

    AXI_RESETN = 1'b0;
    S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    M_AXIS_TREADY = 1'b1;
    reset = 32'd0;
    {mac0_high, mac0_low} = {16'h0000, MAC0};
    {mac1_high, mac1_low} = {16'h0000, MAC1};
    {mac2_high, mac2_low} = {16'hDEAD, MAC2};
    {mac3_high, mac3_low} = {16'h0000, MAC3};

    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    AXI_RESETN = 1'b1;
    stepCycle();

    // Reset state
    checkOutput("rst_tvalid", 256'(M_AXIS_TVALID), 256'(1'b0));
    checkOutput("rst_tdata", M_AXIS_TDATA, 256'd0);
    checkOutput("rst_tready", 256'(S_AXIS_TREADY), 256'(1'b1));
    checkOutput("rst_rewrite_cnt", 256'(rewrite_count), 256'd0);
    checkOutput("rst_passthru_cnt", 256'(passthru_count), 256'd0);

    // Rewrites: port 1 basic case, port 3 checksum carry wrap, and port 0
    // with the smallest TTL that still rewrites.
    sendSingle("ipv4_p1", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861), 8'h04,
               makeBeat(MAC1, 16'h0800, 4'd4, 8'h3F, 16'hB961));
    checkOutput("ipv4_p1_cnt", 256'(rewrite_count), 256'd1);
    sendSingle("wrap_p3", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h05, 16'hFF00), 8'h40,
               makeBeat(MAC3, 16'h0800, 4'd4, 8'h04, 16'h0001));
    sendSingle("ttl2_p0", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h02, 16'h1234), 8'h01,
               makeBeat(MAC0, 16'h0800, 4'd4, 8'h01, 16'h1334));
    checkOutput("rw3_rewrite_cnt", 256'(rewrite_count), 256'd3);
    checkOutput("rw3_passthru_cnt", 256'(passthru_count), 256'd0);

    // Only a value of exactly 1 clears the counters.
    reset = 32'd2;
    stepCycle();
    checkOutput("clr2_keep_cnt", 256'(rewrite_count), 256'd3);
    reset = 32'd1;
    stepCycle();
    reset = 32'd0;
    checkOutput("clr1_rewrite_cnt", 256'(rewrite_count), 256'd0);

    // Pass-through cases
    sendSingle("pt_ttl1", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h01, 16'h5555), 8'h01,
               makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h01, 16'h5555));
    sendSingle("pt_arp", makeBeat(ORIG_SRC, 16'h0806, 4'd4, 8'h40, 16'hB861), 8'h04,
               makeBeat(ORIG_SRC, 16'h0806, 4'd4, 8'h40, 16'hB861));
    sendSingle("pt_cpu", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861), 8'h02,
               makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861));
    sendSingle("pt_multi", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861), 8'h05,
               makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861));
    checkOutput("pt_passthru_cnt", 256'(passthru_count), 256'd4);
    checkOutput("pt_rewrite_cnt", 256'(rewrite_count), 256'd0);

    // Backpressure: 3-beat packet where only the first beat is rewritten.
    // A beat is in flight if it was accepted and not yet delivered. Input
    // ready must drop exactly when two beats are in flight (skid full).
    bpIn[0]  = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h10, 16'hABCD);
    bpExp[0] = makeBeat(MAC1, 16'h0800, 4'd4, 8'h0F, 16'hACCD);
    bpIn[1]  = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h50, 16'h1010);
    bpExp[1] = bpIn[1];
    bpIn[2]  = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h60, 16'h2020);
    bpExp[2] = bpIn[2];
    bpStrb[0] = 32'hFFFF_FFFF; bpStrb[1] = 32'hFFFF_FFFF; bpStrb[2] = 32'h0000_FFFF;
    rdySeq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    inIdx = 0; outIdx = 0; occ = 0; heldValid = 1'b0; held = '0;
    for (int c = 0; c < 20 && outIdx < 3; c++) begin
      M_AXIS_TREADY = (c < 6) ? rdySeq[c] : 1'b1;
      if (inIdx < 3) applyStimulus(bpIn[inIdx], makeUser(8'h04), bpStrb[inIdx], inIdx == 2);
      else S_AXIS_TVALID = 1'b0;
      #1;
      checkOutput("bp_s_ready", 256'(S_AXIS_TREADY), 256'(occ != 2));
      if (heldValid) begin
        checkOutput("bp_stall_valid", 256'(M_AXIS_TVALID), 256'(1'b1));
        checkOutput("bp_stall_data", M_AXIS_TDATA, held);
      end
      inAcc  = S_AXIS_TVALID && S_AXIS_TREADY;
      outAcc = M_AXIS_TVALID && M_AXIS_TREADY;
      if (outAcc) begin
        checkOutput("bp_out_data", M_AXIS_TDATA, bpExp[outIdx]);
        checkOutput("bp_out_strb", 256'(M_AXIS_TSTRB), 256'(bpStrb[outIdx]));
        checkOutput("bp_out_last", 256'(M_AXIS_TLAST), 256'(outIdx == 2));
        outIdx++;
      end
      heldValid = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = M_AXIS_TDATA;
      if (inAcc) inIdx++;
      if (inAcc) occ++;
      if (outAcc) occ--;
      stepCycle();
    end
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;
    checkOutput("bp_all_delivered", 256'(outIdx), 256'd3);
    checkOutput("bp_rewrite_cnt", 256'(rewrite_count), 256'd1);

    // Back-to-back packets: single, two-beat, single, single. A beat goes
    // in and a result comes out every cycle.
    bbIn[0] = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h80, 16'h0000);
    bbExp[0] = makeBeat(MAC2, 16'h0800, 4'd4, 8'h7F, 16'h0100);
    bbDst[0] = 8'h10; bbLast[0] = 1'b1;
    bbIn[1] = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h21, 16'hFEFF);
    bbExp[1] = makeBeat(MAC0, 16'h0800, 4'd4, 8'h20, 16'hFFFF);
    bbDst[1] = 8'h01; bbLast[1] = 1'b0;
    bbIn[2] = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h33, 16'h1111);
    bbExp[2] = bbIn[2];
    bbDst[2] = 8'h01; bbLast[2] = 1'b1;
    bbIn[3] = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h02, 16'hFFFF);
    bbExp[3] = makeBeat(MAC3, 16'h0800, 4'd4, 8'h01, 16'h0100);
    bbDst[3] = 8'h40; bbLast[3] = 1'b1;
    bbIn[4] = makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h00, 16'h4242);
    bbExp[4] = bbIn[4];
    bbDst[4] = 8'h04; bbLast[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bbIn[i], makeUser(bbDst[i]), 32'hFFFF_FFFF, bbLast[i]);
      checkOutput("bb_s_ready", 256'(S_AXIS_TREADY), 256'(1'b1));
      stepCycle();
      checkOutput("bb_valid", 256'(M_AXIS_TVALID), 256'(1'b1));
      checkOutput("bb_data", M_AXIS_TDATA, bbExp[i]);
      checkOutput("bb_last", 256'(M_AXIS_TLAST), 256'(bbLast[i]));
    end
    S_AXIS_TVALID = 1'b0;
    stepCycle();
    checkOutput("bb_rewrite_cnt", 256'(rewrite_count), 256'd4);
    checkOutput("bb_passthru_cnt", 256'(passthru_count), 256'd5);

    // Reset mid-packet: the header sits in the output register and a body
    // beat sits in the skid register when reset asserts.
    M_AXIS_TREADY = 1'b0;
    applyStimulus(makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861), makeUser(8'h04), 32'hFFFF_FFFF, 1'b0);
    stepCycle();
    applyStimulus(makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h44, 16'h0000), makeUser(8'h04), 32'hFFFF_FFFF, 1'b0);
    stepCycle();
    S_AXIS_TVALID = 1'b0;
    checkOutput("mid_skid_full", 256'(S_AXIS_TREADY), 256'(1'b0));
    #2;
    AXI_RESETN = 1'b0;
    #1;
    checkOutput("arst_tvalid", 256'(M_AXIS_TVALID), 256'(1'b0));
    checkOutput("arst_tdata", M_AXIS_TDATA, 256'd0);
    checkOutput("arst_tuser", 256'(M_AXIS_TUSER), 256'd0);
    checkOutput("arst_tlast", 256'(M_AXIS_TLAST), 256'(1'b0));
    checkOutput("arst_tready", 256'(S_AXIS_TREADY), 256'(1'b1));
    checkOutput("arst_rewrite_cnt", 256'(rewrite_count), 256'd0);
    @(negedge AXI_ACLK);
    AXI_RESETN = 1'b1;
    M_AXIS_TREADY = 1'b1;
    stepCycle();

    // After reset the next beat is a header. Its rewrite happens in the same
    // cycle as a counter clear, and the clear wins.
    reset = 32'd1;
    applyStimulus(makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h09, 16'h7000), makeUser(8'h10), 32'hFFFF_FFFF, 1'b1);
    stepCycle();
    S_AXIS_TVALID = 1'b0;
    reset = 32'd0;
    checkOutput("post_rst_valid", 256'(M_AXIS_TVALID), 256'(1'b1));
    checkOutput("post_rst_data", M_AXIS_TDATA, makeBeat(MAC2, 16'h0800, 4'd4, 8'h08, 16'h7100));
    checkOutput("clr_vs_inc_cnt", 256'(rewrite_count), 256'd0);
    stepCycle();
    sendSingle("after_clr", makeBeat(ORIG_SRC, 16'h0800, 4'd4, 8'h40, 16'hB861), 8'h04,
               makeBeat(MAC1, 16'h0800, 4'd4, 8'h3F, 16'hB961));
    checkOutput("after_clr_cnt", 256'(rewrite_count), 256'd1);
    checkOutput("after_clr_pt_cnt", 256'(passthru_count), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
